// File: rtl/jk_bank_if.sv
// jk_bank_if
//   Bundles the requester-side command bus and the shared bank status of
//   jk_bank_arbiter.
//   Ports (signals):
//     req    NREQ        pending-command flags, one per requester
//     j_in   NREQ*WIDTH  J vectors, requester i at [i*WIDTH +: WIDTH]
//     k_in   NREQ*WIDTH  K vectors, requester i at [i*WIDTH +: WIDTH]
//     gnt    NREQ        one-hot registered grant
//     done   1           one-cycle pulse when the bank has been updated
//     busy   1           arbiter is in the middle of a transaction
//     q      WIDTH       shared JK bank state
//   Modports: master = requester side, slave = arbiter side.
interface jk_bank_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
);
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] j_in;
    logic [NREQ*WIDTH-1:0] k_in;
    logic [NREQ-1:0]       gnt;
    logic                  done;
    logic                  busy;
    logic [WIDTH-1:0]      q;

    modport master (
        output req, j_in, k_in,
        input  gnt, done, busy, q
    );

    modport slave (
        input  req, j_in, k_in,
        output gnt, done, busy, q
    );
endinterface

// File: rtl/jk_bank_arbiter.sv
// jk_bank_arbiter
//   Shares one WIDTH-bit bank of JK flip-flops between NREQ requesters.
//   A round-robin arbiter grants one requester, latches its J/K vectors at
//   the grant edge and applies them to the bank in a single update cycle.
//   Ports:
//     clk   rising-edge clock
//     rst   synchronous reset, active-high
//     bus   jk_bank_if.slave: req/j_in/k_in in, gnt/done/busy/q out
//
//   state   | meaning
//   --------+------------------------------------------------------
//   IDLE    | waiting for any req; picks winner from ptr onwards
//   APPLY   | gnt held; bank updated from latched J/K; done pulses
//   RELEASE | gnt dropped; ptr advanced past the winner
module jk_bank_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
) (
    input  logic      clk,
    input  logic      rst,
    jk_bank_if.slave  bus
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        APPLY   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t            state, state_n;
    logic [NREQ-1:0]   gnt_r, gnt_n;
    logic              done_r, done_n;
    logic [WIDTH-1:0]  q_r, q_n;
    logic [WIDTH-1:0]  jl, jl_n;
    logic [WIDTH-1:0]  kl, kl_n;
    logic [PW-1:0]     ptr, ptr_n;
    logic [PW-1:0]     wl, wl_n;

    logic              found;
    logic [PW-1:0]     win;

    // Round-robin pick: first requester at or after ptr, wrapping modulo NREQ.
    always_comb begin
        int idx;
        found = 1'b0;
        win   = ptr;
        idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!found && bus.req[idx]) begin
                found = 1'b1;
                win   = PW'(idx);
            end
        end
    end

    always_comb begin
        state_n = state;
        gnt_n   = gnt_r;
        done_n  = 1'b0;
        q_n     = q_r;
        jl_n    = jl;
        kl_n    = kl;
        ptr_n   = ptr;
        wl_n    = wl;
        case (state)
            IDLE: begin
                gnt_n = '0;
                if (found) begin
                    gnt_n   = NREQ'(1) << win;
                    jl_n    = bus.j_in[int'(win)*WIDTH +: WIDTH];
                    kl_n    = bus.k_in[int'(win)*WIDTH +: WIDTH];
                    wl_n    = win;
                    state_n = APPLY;
                end
            end
            APPLY: begin
                for (int b = 0; b < WIDTH; b++) begin
                    case ({jl[b], kl[b]})
                        2'b01:   q_n[b] = 1'b0;
                        2'b10:   q_n[b] = 1'b1;
                        2'b11:   q_n[b] = ~q_r[b];
                        default: q_n[b] = q_r[b];
                    endcase
                end
                done_n  = 1'b1;
                state_n = RELEASE;
            end
            RELEASE: begin
                gnt_n   = '0;
                ptr_n   = (wl == PW'(NREQ - 1)) ? '0 : wl + PW'(1);
                state_n = IDLE;
            end
            default: begin
                gnt_n   = '0;
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            gnt_r  <= '0;
            done_r <= 1'b0;
            q_r    <= '0;
            jl     <= '0;
            kl     <= '0;
            ptr    <= '0;
            wl     <= '0;
        end else begin
            state  <= state_n;
            gnt_r  <= gnt_n;
            done_r <= done_n;
            q_r    <= q_n;
            jl     <= jl_n;
            kl     <= kl_n;
            ptr    <= ptr_n;
            wl     <= wl_n;
        end
    end

    assign bus.gnt  = gnt_r;
    assign bus.done = done_r;
    assign bus.q    = q_r;
    assign bus.busy = (state != IDLE);
endmodule

// File: tb/tb_jk_bank_arbiter.sv
// tb_jk_bank_arbiter
//   Directed-vector bench for jk_bank_arbiter (NREQ=4, WIDTH=8).
module tb_jk_bank_arbiter;
    localparam int NREQ  = 4;
    localparam int WIDTH = 8;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    logic [7:0] qm;

    jk_bank_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

    jk_bank_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_jk(input int idx, input logic [7:0] j, input logic [7:0] k);
        bus.j_in[idx*WIDTH +: WIDTH] = j;
        bus.k_in[idx*WIDTH +: WIDTH] = k;
    endtask

    // One full transaction by requester idx; if late_chg, J/K are altered
    // right after the grant and must be ignored.
    task automatic do_cmd(input string tag, input int idx, input logic [7:0] j,
                          input logic [7:0] k, input logic [7:0] exp_q, input bit late_chg);
        logic [3:0] g;
        g = 4'b0001 << idx;
        set_jk(idx, j, k);
        bus.req = g;
        tick();
        chk({tag, "_gnt"}, 32'(bus.gnt), 32'(g));
        chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
        if (late_chg) set_jk(idx, ~j, ~k);
        tick();
        chk({tag, "_done"}, 32'(bus.done), 32'd1);
        chk({tag, "_q"}, 32'(bus.q), 32'(exp_q));
        chk({tag, "_gnt_hold"}, 32'(bus.gnt), 32'(g));
        bus.req = '0;
        tick();
        chk({tag, "_gnt_clr"}, 32'(bus.gnt), 32'd0);
        chk({tag, "_done_clr"}, 32'(bus.done), 32'd0);
        chk({tag, "_idle"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        rst      = 1'b1;
        bus.req  = 4'hF;
        bus.j_in = '0;
        bus.k_in = '0;

        // reset held with requests pending
        tick();
        tick();
        chk("rst_q", 32'(bus.q), 32'd0);
        chk("rst_gnt", 32'(bus.gnt), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        bus.req = '0;
        rst     = 1'b0;
        tick();
        chk("idle_gnt", 32'(bus.gnt), 32'd0);

        // ptr=0 -> w=2, ptr becomes 3
        do_cmd("single2", 2, 8'hF0, 8'h0F, 8'hF0, 1'b0);
        // ptr=3, only req1 -> w=1, ptr 2; set/clear to AA
        do_cmd("load_aa", 1, 8'hAA, 8'h55, 8'hAA, 1'b0);
        // toggle all, twice, via requester 0 (ptr 2 -> 1 -> 1)
        do_cmd("tog1", 0, 8'hFF, 8'hFF, 8'h55, 1'b0);
        do_cmd("tog2", 0, 8'hFF, 8'hFF, 8'hAA, 1'b0);
        // hold: q unchanged, done still pulses; w=3 wraps ptr to 0
        do_cmd("hold", 3, 8'h00, 8'h00, 8'hAA, 1'b0);
        // late J/K change after grant ignored; w=2, ptr 3
        do_cmd("latch", 2, 8'h0F, 8'hF0, 8'h0F, 1'b1);

        // reset in APPLY: ptr=3 grants requester 3, abort before update
        set_jk(3, 8'hFF, 8'h00);
        bus.req = 4'b1000;
        tick();
        chk("abort_gnt", 32'(bus.gnt), 32'h8);
        rst = 1'b1;
        tick();
        chk("abort_q", 32'(bus.q), 32'd0);
        chk("abort_done", 32'(bus.done), 32'd0);
        chk("abort_gnt0", 32'(bus.gnt), 32'd0);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        rst = 1'b0;

        // all requesting; requester i toggles bit i. Order must start at 0.
        for (int i = 0; i < NREQ; i++) set_jk(i, 8'h01 << i, 8'h01 << i);
        bus.req = 4'hF;
        qm = 8'h00;
        for (int t = 0; t < 12; t++) begin
            tick();
            chk($sformatf("rr%0d_gnt", t), 32'(bus.gnt), 32'(4'b0001 << (t % 4)));
            chk($sformatf("rr%0d_done0", t), 32'(bus.done), 32'd0);
            qm = qm ^ (8'h01 << (t % 4));
            tick();
            chk($sformatf("rr%0d_done", t), 32'(bus.done), 32'd1);
            chk($sformatf("rr%0d_q", t), 32'(bus.q), 32'(qm));
            tick();
            chk($sformatf("rr%0d_gnt_clr", t), 32'(bus.gnt), 32'd0);
        end
        bus.req = '0;
        tick();
        chk("end_idle", 32'(bus.busy), 32'd0);
        chk("end_q", 32'(bus.q), 32'(qm));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
